// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_rd_stream_adapter_pkg;

  // Default word width of the upstream synchronous FIFO.
  localparam int FIFO_WIDTH = 16;

  // Output buffer occupancy: 0, 1 or 2 entries.
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Words the buffer will hold after this edge if no new read is issued:
  // current occupancy plus the word arriving from the FIFO minus the word
  // leaving to the consumer. A new read is only allowed while this is < 2.
  function automatic logic [2:0] credit_level(input occ_t occ,
                                              input logic inflight,
                                              input logic pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus valid/ready output stream of the adapter.
// master: the adapter side; slave: the FIFO/consumer environment.
interface fifo_rd_stream_adapter_if
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    input  fifo_underflow,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    output fifo_underflow,
    input  fifo_rd_en,
    input  m_valid,
    output m_ready,
    input  m_data
  );

endinterface

// File: rtl/fifo_rd_stream_adapter_rd_skid_buf.sv
// Two-entry output buffer: head is presented to the consumer, tail absorbs
// the word that was already in flight when the consumer stalled.
module rd_skid_buf
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  occ_t                  occ_q, occ_d;

  // Next-state of the two entries; flush only empties, data is left as is.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == OCC_EMPTY) begin
            head_d = din;
          end else begin
            tail_d = din;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == OCC_FULL) begin
            head_d = tail_q;
          end
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the entry order still has to advance.
          if (occ_q == OCC_FULL) begin
            head_d = tail_q;
            tail_d = din;
          end else begin
            head_d = din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Overfilling or popping an empty buffer means the upstream credit rule broke.
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && !pop && occ_q == OCC_FULL));
      assert (!(pop && occ_q == OCC_EMPTY));
    end
  end

  assign dout = head_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the 1-cycle-latency FIFO read port into a valid/ready stream.
// Reads are issued only when the buffer is guaranteed room for the word,
// so a stalled consumer never causes a captured word to be dropped.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH,
  parameter int CNT_WIDTH  = 32,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     flush,
  fifo_rd_stream_adapter_if.master bus,
  output logic [CNT_WIDTH-1:0]     word_cnt,
  output logic [ERR_WIDTH-1:0]     underflow_cnt
);

  occ_t                  occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  m_valid;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            credit;

  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [ERR_WIDTH-1:0]  underflow_cnt_q, underflow_cnt_d;

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .flush (flush),
    .din   (bus.fifo_data_out),
    .dout  (head),
    .occ   (occ)
  );

  assign m_valid = (occ != OCC_EMPTY);

  // Read issue, in-flight tracking and counter next-state.
  always_comb begin
    pop    = m_valid & bus.m_ready;
    credit = credit_level(occ, inflight_q, pop);
    // rst_n keeps the read strobe low while the adapter is held in reset.
    rd_en  = rst_n & enable & ~flush & ~bus.fifo_empty & (credit < 3'd2);
    inflight_d = rd_en;
    word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    underflow_cnt_d = underflow_cnt_q;
    if (bus.fifo_underflow && (underflow_cnt_q != {ERR_WIDTH{1'b1}})) begin
      underflow_cnt_d = underflow_cnt_q + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      word_cnt_q      <= '0;
      underflow_cnt_q <= '0;
    end else begin
      inflight_q      <= inflight_d;
      word_cnt_q      <= word_cnt_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = head;
  assign word_cnt       = word_cnt_q;
  assign underflow_cnt  = underflow_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: a per-cycle vector table driving
// the FIFO port directly, then hand sequences against a small FIFO model.
module tb_fifo_rd_stream_adapter;

  logic clk;
  logic rst_n;
  logic en, fl;
  logic en2;
  logic [31:0] word_cnt;
  logic [7:0]  uf_cnt;
  logic [3:0]  word_cnt2;
  logic [7:0]  uf_cnt2;

  // table drive vs FIFO model drive
  logic        use_model;
  logic        t_empty;
  logic [15:0] t_dout;
  logic        uf;

  logic [15:0] mem [0:255];
  int          wp = 0;
  int          rp = 0;
  logic [15:0] model_dout = 16'h0000;

  int checks = 0;
  int errors = 0;

  fifo_rd_stream_adapter_if #(.DATA_WIDTH(16)) ifc ();
  fifo_rd_stream_adapter_if #(.DATA_WIDTH(16)) ifc2 ();

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (16), .CNT_WIDTH (32), .ERR_WIDTH (8)
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable (en), .flush (fl),
    .bus (ifc), .word_cnt (word_cnt), .underflow_cnt (uf_cnt)
  );

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (16), .CNT_WIDTH (4), .ERR_WIDTH (8)
  ) dut_w (
    .clk (clk), .rst_n (rst_n), .enable (en2), .flush (1'b0),
    .bus (ifc2), .word_cnt (word_cnt2), .underflow_cnt (uf_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifc.fifo_empty     = use_model ? (wp == rp) : t_empty;
  assign ifc.fifo_data_out  = use_model ? model_dout : t_dout;
  assign ifc.fifo_underflow = uf;

  // FIFO model: 1-cycle read latency, data held between reads
  always @(posedge clk) begin
    if (use_model && ifc.fifo_rd_en && (wp != rp)) begin
      model_dout <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end

  typedef struct {
    logic        en, fl, rdy, emp;
    logic [15:0] dout;
    logic        exp_rd, exp_vld;
    logic [15:0] exp_data;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    mem[wp[7:0]] = d;
    wp = wp + 1;
  endtask

  logic [15:0] got [0:31];
  int n;
  int pulses, seen;
  logic [15:0] seen_data;

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0000, 32'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,16'h1111, 1'b1,1'b0,16'h0000, 32'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,16'h2222, 1'b0,1'b1,16'h1111, 32'd0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,16'h2222, 1'b0,1'b1,16'h1111, 32'd0};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,16'h2222, 1'b1,1'b1,16'h1111, 32'd0};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,16'h3333, 1'b1,1'b1,16'h2222, 32'd1};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,16'h4444, 1'b0,1'b1,16'h3333, 32'd2};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,16'h4444, 1'b0,1'b1,16'h4444, 32'd3};
    tbl[8]  = '{1'b1,1'b0,1'b1,1'b1,16'h4444, 1'b0,1'b1,16'h4444, 32'd3};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,16'h4444, 1'b0,1'b0,16'h4444, 32'd4};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,16'h4444, 1'b0,1'b0,16'h4444, 32'd4};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b0,16'h4444, 1'b1,1'b0,16'h4444, 32'd4};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b0,16'h5555, 1'b0,1'b0,16'h4444, 32'd4};
    tbl[13] = '{1'b1,1'b0,1'b1,1'b0,16'h5555, 1'b1,1'b0,16'h4444, 32'd4};
    tbl[14] = '{1'b1,1'b0,1'b1,1'b1,16'h6666, 1'b0,1'b0,16'h4444, 32'd4};
    tbl[15] = '{1'b1,1'b0,1'b1,1'b1,16'h6666, 1'b0,1'b1,16'h6666, 32'd4};

    // reset with reads otherwise permitted
    rst_n = 1'b0; en = 1'b1; fl = 1'b0; uf = 1'b0;
    use_model = 1'b0; t_empty = 1'b0; t_dout = 16'h0000;
    ifc.m_ready = 1'b0;
    en2 = 1'b0;
    ifc2.fifo_empty = 1'b0; ifc2.fifo_data_out = 16'h0077;
    ifc2.fifo_underflow = 1'b0; ifc2.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", {31'd0, ifc.fifo_rd_en}, 32'd0);
    chk("rst_m_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, ifc.m_data}, 32'd0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    chk("rst_uf_cnt", {24'd0, uf_cnt}, 32'd0);
    en = 1'b0; t_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // per-cycle vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en = tbl[i].en; fl = tbl[i].fl; ifc.m_ready = tbl[i].rdy;
      t_empty = tbl[i].emp; t_dout = tbl[i].dout;
      #1;
      chk($sformatf("vec%0d_rd_en", i), {31'd0, ifc.fifo_rd_en}, {31'd0, tbl[i].exp_rd});
      chk($sformatf("vec%0d_m_valid", i), {31'd0, ifc.m_valid}, {31'd0, tbl[i].exp_vld});
      chk($sformatf("vec%0d_m_data", i), {16'd0, ifc.m_data}, {16'd0, tbl[i].exp_data});
      chk($sformatf("vec%0d_word_cnt", i), word_cnt, tbl[i].exp_cnt);
    end

    // throughput: 8 preloaded words, consumer always ready
    @(negedge clk);
    use_model = 1'b1; en = 1'b0; fl = 1'b0; ifc.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      en = 1'b1;
      #1;
      chk($sformatf("tp%0d_rd_en", k), {31'd0, ifc.fifo_rd_en}, (k < 8) ? 32'd1 : 32'd0);
      chk($sformatf("tp%0d_m_valid", k), {31'd0, ifc.m_valid}, (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 9) chk($sformatf("tp%0d_m_data", k), {16'd0, ifc.m_data}, k - 1);
    end
    chk("tp_word_cnt", word_cnt, 32'd13);
    en = 1'b0;

    // backpressure: consumer stalls for 5 cycles mid-stream
    @(negedge clk);
    for (int i = 0; i < 10; i++) push(16'h0101 + 16'(i));
    n = 0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      en = 1'b1;
      ifc.m_ready = (s < 4 || s >= 9);
      #1;
      if (s >= 4 && s <= 8) begin
        chk($sformatf("bp%0d_rd_en", s), {31'd0, ifc.fifo_rd_en}, 32'd0);
        chk($sformatf("bp%0d_m_data", s), {16'd0, ifc.m_data}, 32'h0103);
      end
      if (ifc.m_valid && ifc.m_ready && n < 32) begin
        got[n] = ifc.m_data;
        n++;
      end
    end
    chk("bp_count", n, 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("bp_word%0d", i), {16'd0, got[i]}, 32'h0101 + i);
    chk("bp_word_cnt", word_cnt, 32'd23);
    en = 1'b0;

    // empty boundary: a single word
    @(negedge clk);
    push(16'hBEEF);
    pulses = 0; seen = 0; seen_data = 16'h0000;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      en = 1'b1; ifc.m_ready = 1'b1;
      #1;
      if (ifc.fifo_rd_en) pulses++;
      if (ifc.m_valid) begin
        seen++;
        seen_data = ifc.m_data;
      end
    end
    chk("emp_rd_pulses", pulses, 32'd1);
    chk("emp_valid_cycles", seen, 32'd1);
    chk("emp_m_data", {16'd0, seen_data}, 32'hBEEF);
    chk("emp_rd_en_idle", {31'd0, ifc.fifo_rd_en}, 32'd0);
    chk("emp_uf_cnt", {24'd0, uf_cnt}, 32'd0);
    chk("emp_word_cnt", word_cnt, 32'd24);
    en = 1'b0;

    // flush the cycle after a read: that word is dropped
    @(negedge clk);
    push(16'hA0A0); push(16'hA1A1);
    @(negedge clk);
    en = 1'b1; ifc.m_ready = 1'b1; fl = 1'b0;
    #1 chk("fl_s0_rd_en", {31'd0, ifc.fifo_rd_en}, 32'd1);
    @(negedge clk);
    fl = 1'b1;
    #1 chk("fl_s1_rd_en", {31'd0, ifc.fifo_rd_en}, 32'd0);
    @(negedge clk);
    fl = 1'b0;
    #1;
    chk("fl_s2_m_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("fl_s2_rd_en", {31'd0, ifc.fifo_rd_en}, 32'd1);
    @(negedge clk);
    #1 chk("fl_s3_m_valid", {31'd0, ifc.m_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("fl_s4_m_valid", {31'd0, ifc.m_valid}, 32'd1);
    chk("fl_s4_m_data", {16'd0, ifc.m_data}, 32'hA1A1);
    @(negedge clk);
    #1;
    chk("fl_s5_m_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("fl_word_cnt", word_cnt, 32'd25);
    en = 1'b0;

    // underflow counter saturation
    @(negedge clk);
    uf = 1'b1;
    repeat (100) @(negedge clk);
    #1 chk("uf_cnt_100", {24'd0, uf_cnt}, 32'd100);
    repeat (200) @(negedge clk);
    #1 chk("uf_cnt_sat", {24'd0, uf_cnt}, 32'hFF);
    uf = 1'b0;
    @(negedge clk);
    #1 chk("uf_cnt_hold", {24'd0, uf_cnt}, 32'hFF);

    // reset mid-stream: buffered and in-flight words are lost
    @(negedge clk);
    for (int i = 1; i <= 5; i++) push(16'h0C00 + 16'(i));
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      en = 1'b1; ifc.m_ready = 1'b1;
      #1;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_m_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("mrst_rd_en", {31'd0, ifc.fifo_rd_en}, 32'd0);
    chk("mrst_word_cnt", word_cnt, 32'd0);
    chk("mrst_uf_cnt", {24'd0, uf_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      #1;
      if (ifc.m_valid && ifc.m_ready && n < 32) begin
        got[n] = ifc.m_data;
        n++;
      end
    end
    chk("mrst_count", n, 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("mrst_word%0d", i), {16'd0, got[i]}, 32'h0C03 + i);
    chk("mrst_word_cnt_after", word_cnt, 32'd3);
    en = 1'b0;

    // 4-bit word counter wraps after 17 pops
    for (int s = 0; s < 17; s++) begin
      @(negedge clk);
      en2 = 1'b1;
    end
    @(negedge clk);
    en2 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("wrap_word_cnt", {28'd0, word_cnt2}, 32'd1);
    chk("wrap_m_valid", {31'd0, ifc2.m_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
